// File: rtl/dm_arbiter.sv
// Two-requester (CPU, loader) arbiter for a single data memory with fixed read latency.
// Round-robin on ties; one transaction at a time; outputs and rdata are registered.
module dm_arbiter #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t              state_q, state_d;
  logic                owner_q, owner_d;        // 0 = CPU, 1 = loader
  logic                last_owner_q, last_owner_d;
  logic                we_q, we_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   ldr_rdata_q, ldr_rdata_d;
  logic                cpu_gnt_q, cpu_gnt_d;
  logic                ldr_gnt_q, ldr_gnt_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                ldr_ack_q, ldr_ack_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic                busy_q, busy_d;
  logic                win;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    ldr_rdata_d  = ldr_rdata_q;
    cpu_gnt_d    = 1'b0;
    ldr_gnt_d    = 1'b0;
    cpu_ack_d    = 1'b0;
    ldr_ack_d    = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    win          = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_req || ldr_req) begin
          // On a tie the requester that did not win last time goes first.
          win          = (cpu_req && ldr_req) ? ~last_owner_q : ldr_req;
          state_d      = GRANT;
          owner_d      = win;
          last_owner_d = win;
          we_d         = win ? ldr_we : cpu_we;
          mem_addr_d   = win ? ldr_addr : cpu_addr;
          mem_wdata_d  = win ? ldr_wdata : cpu_wdata;
          cpu_gnt_d    = ~win;
          ldr_gnt_d    = win;
          mem_en_d     = 1'b1;
          mem_we_d     = win ? ldr_we : cpu_we;
        end
      end
      GRANT: begin
        state_d = WAIT;
        cnt_d   = LAT_M1;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (!we_q) begin
            if (owner_q) ldr_rdata_d = mem_rdata;
            else         cpu_rdata_d = mem_rdata;
          end
          cpu_ack_d = ~owner_q;
          ldr_ack_d = owner_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      cnt_q        <= 4'd0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
      cpu_gnt_q    <= 1'b0;
      ldr_gnt_q    <= 1'b0;
      cpu_ack_q    <= 1'b0;
      ldr_ack_q    <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ldr_rdata_q  <= ldr_rdata_d;
      cpu_gnt_q    <= cpu_gnt_d;
      ldr_gnt_q    <= ldr_gnt_d;
      cpu_ack_q    <= cpu_ack_d;
      ldr_ack_q    <= ldr_ack_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      busy_q       <= busy_d;
    end
  end

  assign cpu_gnt   = cpu_gnt_q;
  assign ldr_gnt   = ldr_gnt_q;
  assign cpu_ack   = cpu_ack_q;
  assign ldr_ack   = ldr_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: u1 runs with MEM_LAT=1, u3 with MEM_LAT=3 (CPU side only).
module tb_dm_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, ldr_req, ldr_we, c3_req;
  logic [3:0]  cpu_addr, ldr_addr;
  logic [15:0] cpu_wdata, ldr_wdata;

  logic        c1_gnt, c1_ack, l1_gnt, l1_ack, m1_en, m1_we, busy1;
  logic [15:0] c1_rdata, l1_rdata, m1_wdata, m1_rdata;
  logic [3:0]  m1_addr;

  logic        c3_gnt, c3_ack, l3_gnt, l3_ack, m3_en, m3_we, busy3;
  logic [15:0] c3_rdata, l3_rdata, m3_wdata, m3_rdata;
  logic [3:0]  m3_addr;

  int errors = 0;
  int checks = 0;

  dm_arbiter #(.DATA_W(16), .ADDR_W(4), .MEM_LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(c1_gnt), .cpu_ack(c1_ack), .cpu_rdata(c1_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(l1_gnt), .ldr_ack(l1_ack), .ldr_rdata(l1_rdata),
    .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
    .mem_rdata(m1_rdata), .busy(busy1)
  );

  dm_arbiter #(.DATA_W(16), .ADDR_W(4), .MEM_LAT(3)) u3 (
    .clk(clk), .rst(rst),
    .cpu_req(c3_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(c3_gnt), .cpu_ack(c3_ack), .cpu_rdata(c3_rdata),
    .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(4'h0), .ldr_wdata(16'h0000),
    .ldr_gnt(l3_gnt), .ldr_ack(l3_ack), .ldr_rdata(l3_rdata),
    .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
    .mem_rdata(m3_rdata), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_word(input logic [3:0] a);
    case (a)
      4'h3:    init_word = 16'hBEEF;
      4'h5:    init_word = 16'hCAFE;
      4'h7:    init_word = 16'h7777;
      4'hA:    init_word = 16'h0A0A;
      default: init_word = {12'h000, a};
    endcase
  endfunction

  // Memory models: read data is only valid in the cycle exactly MEM_LAT after mem_en,
  // otherwise a poison value is driven so a mistimed capture is visible.
  logic [15:0] mem1 [16];
  logic [15:0] p1;
  logic        v1;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem1[i] <= init_word(4'(i));
    end else if (m1_en && m1_we) begin
      mem1[m1_addr] <= m1_wdata;
    end
    p1 <= mem1[m1_addr];
    v1 <= m1_en && !m1_we;
  end
  assign m1_rdata = v1 ? p1 : 16'hDEAD;

  logic [15:0] p3 [3];
  logic        v3 [3];
  always @(posedge clk) begin
    p3[0] <= init_word(m3_addr);
    v3[0] <= m3_en && !m3_we;
    p3[1] <= p3[0];
    v3[1] <= v3[0];
    p3[2] <= p3[1];
    v3[2] <= v3[1];
  end
  assign m3_rdata = v3[2] ? p3[2] : 16'hDEAD;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 4'h0; cpu_wdata = 16'h0000;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 4'h0; ldr_wdata = 16'h0000;
    c3_req = 1'b0;

    // Reset state
    tick(); tick();
    chk1("rst_busy", busy1, 1'b0);
    chk1("rst_cpu_gnt", c1_gnt, 1'b0);
    chk1("rst_ldr_ack", l1_ack, 1'b0);
    chk1("rst_mem_en", m1_en, 1'b0);
    chk16("rst_mem_addr", {12'h000, m1_addr}, 16'h0000);
    chk16("rst_cpu_rdata", c1_rdata, 16'h0000);
    rst = 1'b0;
    tick();
    chk1("post_rst_busy", busy1, 1'b0);

    // CPU read addr 3, MEM_LAT=1
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3;
    tick();
    chk1("rd_grant_gnt", c1_gnt, 1'b1);
    chk1("rd_grant_ldr_gnt", l1_gnt, 1'b0);
    chk1("rd_grant_en", m1_en, 1'b1);
    chk1("rd_grant_we", m1_we, 1'b0);
    chk16("rd_grant_addr", {12'h000, m1_addr}, 16'h0003);
    chk1("rd_grant_busy", busy1, 1'b1);
    tick();
    chk1("rd_wait_gnt", c1_gnt, 1'b0);
    chk1("rd_wait_en", m1_en, 1'b0);
    chk1("rd_wait_ack", c1_ack, 1'b0);
    chk16("rd_wait_addr_hold", {12'h000, m1_addr}, 16'h0003);
    tick();
    chk1("rd_done_ack", c1_ack, 1'b1);
    chk16("rd_done_rdata", c1_rdata, 16'hBEEF);
    chk1("rd_done_busy", busy1, 1'b1);
    cpu_req = 1'b0;
    tick();
    chk1("rd_idle_ack", c1_ack, 1'b0);
    chk1("rd_idle_busy", busy1, 1'b0);
    tick();
    chk1("rd_idle2_busy", busy1, 1'b0);

    // Loader write addr A = 1234
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 4'hA; ldr_wdata = 16'h1234;
    tick();
    chk1("wr_grant_gnt", l1_gnt, 1'b1);
    chk1("wr_grant_cpu_gnt", c1_gnt, 1'b0);
    chk1("wr_grant_en", m1_en, 1'b1);
    chk1("wr_grant_we", m1_we, 1'b1);
    chk16("wr_grant_addr", {12'h000, m1_addr}, 16'h000A);
    chk16("wr_grant_wdata", m1_wdata, 16'h1234);
    tick();
    chk1("wr_wait_en", m1_en, 1'b0);
    chk1("wr_wait_we", m1_we, 1'b0);
    chk16("wr_wait_wdata_hold", m1_wdata, 16'h1234);
    tick();
    chk1("wr_done_ack", l1_ack, 1'b1);
    chk1("wr_done_cpu_ack", c1_ack, 1'b0);
    chk16("wr_done_ldr_rdata", l1_rdata, 16'h0000);
    ldr_req = 1'b0;
    tick();
    chk1("wr_idle_ack", l1_ack, 1'b0);

    // Loader read back addr A
    ldr_req = 1'b1; ldr_we = 1'b0;
    tick(); tick(); tick();
    chk1("rb_done_ack", l1_ack, 1'b1);
    chk16("rb_ldr_rdata", l1_rdata, 16'h1234);
    chk16("rb_cpu_rdata_hold", c1_rdata, 16'hBEEF);
    ldr_req = 1'b0;
    tick();

    // CPU read addr 5, req dropped during WAIT
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h5;
    tick();
    chk1("drop_grant_gnt", c1_gnt, 1'b1);
    tick();
    cpu_req = 1'b0;
    tick();
    chk1("drop_done_ack", c1_ack, 1'b1);
    chk16("drop_done_rdata", c1_rdata, 16'hCAFE);
    tick();
    chk1("drop_idle_ack", c1_ack, 1'b0);
    tick();
    chk1("drop_no_retrigger", busy1, 1'b0);

    // Reset raised during WAIT of a CPU read of addr 7
    cpu_req = 1'b1; cpu_addr = 4'h7;
    tick(); tick();
    chk1("abort_in_wait_busy", busy1, 1'b1);
    rst = 1'b1; cpu_req = 1'b0;
    #1;
    chk1("abort_busy", busy1, 1'b0);
    chk1("abort_ack", c1_ack, 1'b0);
    chk1("abort_en", m1_en, 1'b0);
    chk16("abort_cpu_rdata", c1_rdata, 16'h0000);
    chk16("abort_ldr_rdata", l1_rdata, 16'h0000);
    tick();
    rst = 1'b0;
    tick();
    chk1("abort_after_busy", busy1, 1'b0);
    chk1("abort_after_ack", c1_ack, 1'b0);
    tick();
    chk1("abort_after_ack2", c1_ack, 1'b0);
    chk1("abort_after_en", m1_en, 1'b0);

    // Tie after reset: CPU, then loader, then CPU
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 4'hA;
    tick();
    chk1("tie1_cpu_gnt", c1_gnt, 1'b1);
    chk1("tie1_ldr_gnt", l1_gnt, 1'b0);
    tick(); tick();
    chk1("tie1_cpu_ack", c1_ack, 1'b1);
    chk1("tie1_ldr_ack", l1_ack, 1'b0);
    chk16("tie1_cpu_rdata", c1_rdata, 16'hBEEF);
    tick();
    chk1("tie_idle_busy", busy1, 1'b0);
    tick();
    chk1("tie2_ldr_gnt", l1_gnt, 1'b1);
    chk1("tie2_cpu_gnt", c1_gnt, 1'b0);
    chk16("tie2_addr", {12'h000, m1_addr}, 16'h000A);
    tick(); tick();
    chk1("tie2_ldr_ack", l1_ack, 1'b1);
    chk1("tie2_cpu_ack", c1_ack, 1'b0);
    chk16("tie2_ldr_rdata", l1_rdata, 16'h0A0A);
    tick(); tick();
    chk1("tie3_cpu_gnt", c1_gnt, 1'b1);
    chk1("tie3_ldr_gnt", l1_gnt, 1'b0);
    cpu_req = 1'b0; ldr_req = 1'b0;
    tick(); tick();
    chk1("tie3_cpu_ack", c1_ack, 1'b1);
    tick();
    chk1("tie3_idle", busy1, 1'b0);

    // MEM_LAT=3 CPU read addr 3
    cpu_we = 1'b0; cpu_addr = 4'h3; cpu_wdata = 16'h0000;
    c3_req = 1'b1;
    tick();
    chk1("lat3_gnt", c3_gnt, 1'b1);
    chk1("lat3_en", m3_en, 1'b1);
    chk16("lat3_wdata", m3_wdata, 16'h0000);
    tick();
    chk1("lat3_w1_ack", c3_ack, 1'b0);
    chk1("lat3_w1_busy", busy3, 1'b1);
    tick();
    chk1("lat3_w2_ack", c3_ack, 1'b0);
    tick();
    chk1("lat3_w3_ack", c3_ack, 1'b0);
    chk1("lat3_w3_en", m3_en, 1'b0);
    tick();
    chk1("lat3_done_ack", c3_ack, 1'b1);
    chk16("lat3_rdata", c3_rdata, 16'hBEEF);
    chk1("lat3_ldr_gnt", l3_gnt, 1'b0);
    chk1("lat3_ldr_ack", l3_ack, 1'b0);
    chk16("lat3_ldr_rdata", l3_rdata, 16'h0000);
    c3_req = 1'b0;
    tick();
    chk1("lat3_idle_ack", c3_ack, 1'b0);
    chk1("lat3_idle_busy", busy3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set data width of all data ports.
REQ-002 Parameter ADDR_W, default 4, SHALL set address width of all address ports.
REQ-003 Parameter MEM_LAT, default 1, range 1..15, SHALL set data-memory read latency in cycles.
REQ-004 Ports SHALL be, in order:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  CPU access request, held until cpu_ack.
- cpu_we  in  1  CPU write (1) / read (0).
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU granted; high in the GRANT cycle only.
- cpu_ack  out  1  CPU transaction complete, 1-cycle pulse.
- cpu_rdata  out  DATA_W  CPU read data, valid when cpu_ack=1.
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_gnt, ldr_ack, ldr_rdata  SHALL have the same directions, widths and meanings for the loader/debug requester.
- mem_en  out  1  data-memory access strobe.
- mem_we  out  1  data-memory write enable.
- mem_addr  out  ADDR_W  data-memory address.
- mem_wdata  out  DATA_W  data-memory write data.
- mem_rdata  in  DATA_W  data-memory read data, valid MEM_LAT cycles after the mem_en cycle.
- busy  out  1  high in any state other than IDLE.

Function
REQ-005 The FSM SHALL have states IDLE, GRANT, WAIT and DONE.
REQ-006 In IDLE with at least one req high at a rising edge, the FSM SHALL move to GRANT and latch owner, we, addr and wdata of the winner.
REQ-007 A single requester SHALL win; with both requesting, the requester not in last_owner SHALL win.
REQ-008 last_owner SHALL update to the winner on every grant.
REQ-009 In GRANT, the winner's gnt SHALL be 1 and mem_en SHALL be 1, with mem_we, mem_addr and mem_wdata taken from the latched values.
REQ-010 GRANT SHALL always last exactly one cycle and then go to WAIT.
REQ-011 WAIT SHALL last exactly MEM_LAT cycles, counted with a 4-bit down-counter loaded with MEM_LAT-1 on entry.
REQ-012 On the last WAIT edge, mem_rdata SHALL be captured into the owner's rdata register when the access is a read.
REQ-013 On a write, rdata SHALL hold its previous value.
REQ-014 In DONE, the owner's ack SHALL be 1 for one cycle, and the FSM SHALL then return to IDLE.
REQ-015 Latency SHALL be MEM_LAT+2 cycles from the sampling edge of req to the ack cycle.
REQ-016 Outside GRANT, mem_en and mem_we SHALL be 0, and mem_addr and mem_wdata SHALL hold their last driven values.
REQ-017 A requester SHALL drop req in its ack cycle; a req still high in IDLE SHALL start a new transaction.
REQ-018 A req deasserted after grant SHALL NOT abort the transaction; ack SHALL still pulse.
REQ-019 A req change during GRANT, WAIT or DONE SHALL have no effect on the current transaction, since latched values are used throughout.
REQ-020 The non-owner's gnt and ack SHALL stay 0 for the whole transaction.
REQ-021 A req of the non-owner that is held during a transaction SHALL be served next, per REQ-007, with no starvation.
REQ-022 The rdata outputs SHALL be registered and SHALL hold their value until the next read completes for that requester.

Reset
REQ-023 While rst=1, the state SHALL be IDLE, and last_owner SHALL be the loader, so that the CPU wins the first tie.
REQ-024 While rst=1, all gnt, ack, mem_en, mem_we and busy outputs SHALL be 0.
REQ-025 While rst=1, mem_addr, mem_wdata and both rdata registers SHALL be 0, and the counter SHALL be 0.
REQ-026 Reset asserted mid-transaction SHALL abort the transaction immediately with no ack and no further mem_en.
REQ-027 An abort caused by reset asserted during a write's GRANT cycle SHALL NOT be re-issued.

Verification
REQ-028 Scenario: CPU read only, addr 4'h3, memory word 16'hBEEF, MEM_LAT=1 -> GRANT with mem_en=1, addr 3, then WAIT, then DONE with cpu_ack=1 and cpu_rdata=16'hBEEF, 3 cycles after the sampling edge.
REQ-029 Scenario: cpu_req and ldr_req rise together after reset, both holding req -> CPU granted first, loader granted in the next IDLE, then CPU again (alternation).
REQ-030 Scenario: loader write addr 4'hA, data 16'h1234 -> one mem_en cycle with mem_we=1, addr A, data 1234; ldr_ack pulses; ldr_rdata unchanged.
REQ-031 Scenario: MEM_LAT=3, CPU read -> WAIT lasts 3 cycles and cpu_ack arrives 5 cycles after the sampling edge.
REQ-032 Scenario: cpu_req dropped in the WAIT cycle -> cpu_ack still pulses once with correct data.
REQ-033 Scenario: rst raised in WAIT -> all outputs 0 immediately; after release, busy=0 and no ack occurs.
